display_fb_axi_slave: RTL and testbench
=======================================

# display_fb_axi_slave

AXI4 full slave that terminates burst traffic from the MIPSfpga system interconnect into the display frame-buffer RAM and exposes a second, read-only pixel port to the scan-out engine. Supports FIXED, INCR and WRAP bursts of up to 256 beats at 32-bit width, one outstanding transaction at a time, and answers every transfer with OKAY. It sits directly downstream of the AXI4 master port in the display block design.

## Interface

- `C_S_AXI_ID_WIDTH`, 4: AXI ID width.
- `C_S_AXI_ADDR_WIDTH`, 32: AXI address width.
- `C_FB_WORDS_LOG2`, 12: frame-buffer depth is 2^N 32-bit words.

- `S_AXI_ACLK`  in  1: sole clock.
- `S_AXI_ARESETN`  in  1: asynchronous, active-low reset.
- `S_AXI_AWID`/`AWADDR`/`AWLEN[7:0]`/`AWSIZE[2:0]`/`AWBURST[1:0]`/`AWVALID`  in: write address channel. `AWREADY` is an output.
- `S_AXI_WDATA[31:0]`/`WSTRB[3:0]`/`WLAST`/`WVALID`  in: write data channel. `WREADY` is an output.
- `S_AXI_BID`/`BRESP[1:0]`/`BVALID`  out; `S_AXI_BREADY`  in: write response channel.
- `S_AXI_ARID`/`ARADDR`/`ARLEN`/`ARSIZE`/`ARBURST`/`ARVALID`  in: read address channel. `ARREADY` is an output.
- `S_AXI_RID`/`RDATA[31:0]`/`RRESP[1:0]`/`RLAST`/`RVALID`  out; `S_AXI_RREADY`  in: read data channel.
- The AXI4 lock, cache, prot, qos, region and user inputs are accepted and ignored.
- `pix_addr`  in  `C_FB_WORDS_LOG2`: scan-out word address.
- `pix_data`  out  32: RAM word at `pix_addr`, valid one cycle after the address.

## Operation

- States: IDLE, WDATA, WRESP, RDATA.
- **IDLE**
  - `AWREADY` = `ARREADY` = 1.
  - If `AWVALID` is high (regardless of `ARVALID`), capture ID, address, length and burst type, then go to WDATA.
  - Otherwise, if `ARVALID` is high, capture the read request and go to RDATA.
  - Write always wins a simultaneous request.
- **WDATA**
  - `WREADY` = 1.
  - Each W handshake writes the lanes of the current word that are enabled by `WSTRB`, then advances the address.
  - On the handshake with beat count == LEN: go to WRESP. `WLAST` is not used for termination.
- **WRESP**
  - `BVALID` = 1, `BID` = the captured ID, `BRESP` = 00.
  - On `BREADY`, go to IDLE.
- **RDATA**
  - Streams LEN+1 beats.
  - `RLAST` = 1 on the beat where count == LEN.
  - `RID` = the captured ID, `RRESP` = 00.
  - After the final handshake, go to IDLE.
- Address arithmetic is on byte addresses; the word index is addr[C_FB_WORDS_LOG2+1:2]. Addresses above the RAM alias modulo its size.
  - FIXED: the address does not change.
  - INCR: addr += 4.
  - WRAP: mask = (LEN+1)*4-1; next = (addr & ~mask) | ((addr+4) & mask). LEN must be 1, 3, 7 or 15; any other value is treated as INCR.
  - `AxBURST` = 11 is treated as INCR.
- `AxSIZE` is ignored; every beat is 4 bytes.
- RAM is true dual-port: port A is AXI read/write, port B is the pixel read-only port. A same-address collision on port B returns the old data.

## Timing

- Reset values: all READY/VALID outputs 0, `BRESP`/`RRESP` 0, `RLAST` 0, IDs 0, `RDATA` 0, state IDLE. `pix_data` is undefined until the first clock after reset.
- The AW or AR handshake takes 1 cycle. WREADY rises in the next cycle.
- Write data is stored in the RAM in the cycle of the W handshake. BVALID rises the cycle after the last W handshake.
- Read latency: RVALID rises 2 cycles after the AR handshake, because the RAM read is synchronous.
- Read throughput is one beat per cycle while `RREADY` = 1.
  - Port A reads the next address on a handshake and the current address otherwise.
  - Under `RREADY` = 0, `RDATA` stays stable and is not corrupted.
- A write data beat with `WVALID` low is simply not consumed. There is no timeout.
- When `S_AXI_ARESETN` is asserted mid-burst, the FSM goes to IDLE immediately and all outputs take their reset values. RAM contents are not cleared; a partial burst stays partially written.
- A new request is accepted no earlier than the cycle after `BVALID`&`BREADY` or the last R handshake.

## Configuration

- `DISPLAY_FB_WRAP_EN`
  - Defined: WRAP bursts follow the mask rule above.
  - Undefined: the WRAP logic is not compiled, and every WRAP burst is treated as INCR. AXI behaviour is otherwise unchanged.

## Test plan

- 16-beat INCR write at 0x0 with words 0xFFFFFFFF..0x00ABCDEF, then a 16-beat INCR read at 0x0 → the same 16 words, RLAST only on beat 15, BRESP/RRESP = 00.
- With `DISPLAY_FB_WRAP_EN`: 4-beat WRAP read at 0x8 after writing words 0..3 = 0xA0..0xA3 → data A2, A3, A0, A1. Without the macro → A2, A3, then words 4 and 5.
- Single write of 0x12345678 with WSTRB = 0011 onto 0xFFFFFFFF → readback 0xFFFF5678. A subsequent `pix_addr` of that word gives the same value one cycle later.
- AWVALID and ARVALID in the same cycle on the same address → the write completes first, and the read returns the new data. ARREADY stays low until BVALID&BREADY.
- 8-beat read with RREADY toggled 1,0,0,1,... → no beat is lost or duplicated, RDATA is stable while stalled, and RLAST falls on beat 7.
- `S_AXI_ARESETN` pulsed low after beat 5 of a 16-beat write → all outputs at reset values. A following 16-beat read shows beats 0-5 new and 6-15 old. A fresh burst then completes normally.

Source files
------------

// File: rtl/display_fb_axi_slave.sv
// AXI4 burst slave in front of a true dual-port frame-buffer RAM with a read-only pixel port.
// Build option: define DISPLAY_FB_WRAP_EN to honour WRAP bursts; otherwise WRAP runs as INCR.
module display_fb_axi_slave #(
  parameter int C_S_AXI_ID_WIDTH   = 4,
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_FB_WORDS_LOG2    = 12
) (
  input  logic                          S_AXI_ACLK,
  input  logic                          S_AXI_ARESETN,
  input  logic [C_S_AXI_ID_WIDTH-1:0]   S_AXI_AWID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
  input  logic [7:0]                    S_AXI_AWLEN,
  input  logic [2:0]                    S_AXI_AWSIZE,
  input  logic [1:0]                    S_AXI_AWBURST,
  input  logic                          S_AXI_AWLOCK,
  input  logic [3:0]                    S_AXI_AWCACHE,
  input  logic [2:0]                    S_AXI_AWPROT,
  input  logic [3:0]                    S_AXI_AWQOS,
  input  logic [3:0]                    S_AXI_AWREGION,
  input  logic                          S_AXI_AWVALID,
  output logic                          S_AXI_AWREADY,
  input  logic [31:0]                   S_AXI_WDATA,
  input  logic [3:0]                    S_AXI_WSTRB,
  input  logic                          S_AXI_WLAST,
  input  logic                          S_AXI_WVALID,
  output logic                          S_AXI_WREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]   S_AXI_BID,
  output logic [1:0]                    S_AXI_BRESP,
  output logic                          S_AXI_BVALID,
  input  logic                          S_AXI_BREADY,
  input  logic [C_S_AXI_ID_WIDTH-1:0]   S_AXI_ARID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic [7:0]                    S_AXI_ARLEN,
  input  logic [2:0]                    S_AXI_ARSIZE,
  input  logic [1:0]                    S_AXI_ARBURST,
  input  logic                          S_AXI_ARLOCK,
  input  logic [3:0]                    S_AXI_ARCACHE,
  input  logic [2:0]                    S_AXI_ARPROT,
  input  logic [3:0]                    S_AXI_ARQOS,
  input  logic [3:0]                    S_AXI_ARREGION,
  input  logic                          S_AXI_ARVALID,
  output logic                          S_AXI_ARREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]   S_AXI_RID,
  output logic [31:0]                   S_AXI_RDATA,
  output logic [1:0]                    S_AXI_RRESP,
  output logic                          S_AXI_RLAST,
  output logic                          S_AXI_RVALID,
  input  logic                          S_AXI_RREADY,
  input  logic [C_FB_WORDS_LOG2-1:0]    pix_addr,
  output logic [31:0]                   pix_data,
  output logic [1:0]                    fsm_state
);
  localparam int ADDR_W = C_S_AXI_ADDR_WIDTH;
  localparam int LW     = C_FB_WORDS_LOG2;
  localparam int DEPTH  = 1 << LW;

  // Handshake rule on every channel: a beat transfers on the rising edge where VALID and READY are both high.
  typedef enum logic [1:0] {IDLE, WDATA, WRESP, RDATA} state_t;
  state_t state;

  logic [31:0]                 mem [DEPTH];
  logic [C_S_AXI_ID_WIDTH-1:0] id_q;
  logic [ADDR_W-1:0]           addr_q, addr_inc, addr_nxt, rd_addr;
  logic [7:0]                  len_q, cnt;
  logic [1:0]                  burst_q;
  logic                        rdy_q, wr_en, rd_hs;
  logic                        unused_inputs;

  assign fsm_state     = state;
  assign S_AXI_AWREADY = rdy_q;
  // A pending write wins, so ARREADY drops while AWVALID is up rather than accepting a read it would drop.
  assign S_AXI_ARREADY = rdy_q & ~S_AXI_AWVALID;
  assign S_AXI_BID     = id_q;
  assign S_AXI_RID     = id_q;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_RRESP   = 2'b00;

`ifdef DISPLAY_FB_WRAP_EN
  logic [ADDR_W-1:0] wrap_mask;
  assign wrap_mask = ADDR_W'({len_q, 2'b11});
`endif

  always_comb begin
    addr_inc = addr_q + ADDR_W'(4);
    addr_nxt = addr_inc;
    if (burst_q == 2'b00) addr_nxt = addr_q;
`ifdef DISPLAY_FB_WRAP_EN
    else if (burst_q == 2'b10 &&
             (len_q == 8'd1 || len_q == 8'd3 || len_q == 8'd7 || len_q == 8'd15))
      addr_nxt = (addr_q & ~wrap_mask) | (addr_inc & wrap_mask);
`endif
  end

  // Port A pre-fetches the following word on a read handshake, otherwise re-reads the current one.
  assign rd_hs   = S_AXI_RVALID & S_AXI_RREADY;
  assign rd_addr = rd_hs ? addr_nxt : addr_q;
  assign wr_en   = (state == WDATA) & S_AXI_WVALID;

  always_ff @(posedge S_AXI_ACLK) begin
    if (wr_en)
      for (int b = 0; b < 4; b++)
        if (S_AXI_WSTRB[b]) mem[addr_q[LW+1:2]][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
    pix_data <= mem[pix_addr];
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state        <= IDLE;
      rdy_q        <= 1'b0;
      S_AXI_WREADY <= 1'b0;
      S_AXI_BVALID <= 1'b0;
      S_AXI_RVALID <= 1'b0;
      S_AXI_RLAST  <= 1'b0;
      S_AXI_RDATA  <= '0;
      id_q         <= '0;
      addr_q       <= '0;
      len_q        <= '0;
      burst_q      <= '0;
      cnt          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (rdy_q && S_AXI_AWVALID) begin
            id_q <= S_AXI_AWID; addr_q <= S_AXI_AWADDR;
            len_q <= S_AXI_AWLEN; burst_q <= S_AXI_AWBURST;
            cnt <= '0; rdy_q <= 1'b0; S_AXI_WREADY <= 1'b1;
            state <= WDATA;
          end else if (rdy_q && S_AXI_ARVALID) begin
            id_q <= S_AXI_ARID; addr_q <= S_AXI_ARADDR;
            len_q <= S_AXI_ARLEN; burst_q <= S_AXI_ARBURST;
            cnt <= '0; rdy_q <= 1'b0;
            state <= RDATA;
          end else begin
            rdy_q <= 1'b1;
          end
        end
        WDATA: begin
          if (S_AXI_WVALID) begin
            addr_q <= addr_nxt;
            cnt    <= cnt + 8'd1;
            if (cnt == len_q) begin
              S_AXI_WREADY <= 1'b0;
              S_AXI_BVALID <= 1'b1;
              state        <= WRESP;
            end
          end
        end
        WRESP: begin
          if (S_AXI_BREADY) begin
            S_AXI_BVALID <= 1'b0;
            rdy_q        <= 1'b1;
            state        <= IDLE;
          end
        end
        RDATA: begin
          S_AXI_RDATA <= mem[rd_addr[LW+1:2]];
          if (!S_AXI_RVALID) begin
            S_AXI_RVALID <= 1'b1;
            S_AXI_RLAST  <= (cnt == len_q);
          end else if (S_AXI_RREADY) begin
            if (cnt == len_q) begin
              S_AXI_RVALID <= 1'b0;
              S_AXI_RLAST  <= 1'b0;
              rdy_q        <= 1'b1;
              state        <= IDLE;
            end else begin
              addr_q      <= addr_nxt;
              cnt         <= cnt + 8'd1;
              S_AXI_RLAST <= ((cnt + 8'd1) == len_q);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign unused_inputs = ^{S_AXI_AWSIZE, S_AXI_AWLOCK, S_AXI_AWCACHE, S_AXI_AWPROT, S_AXI_AWQOS,
                           S_AXI_AWREGION, S_AXI_ARSIZE, S_AXI_ARLOCK, S_AXI_ARCACHE, S_AXI_ARPROT,
                           S_AXI_ARQOS, S_AXI_ARREGION, S_AXI_WLAST,
                           rd_addr[ADDR_W-1:LW+2], rd_addr[1:0]};
endmodule

// File: tb/tb_display_fb_axi_slave.sv
// Randomized bench for display_fb_axi_slave against a word-array model of the frame buffer.
module tb_display_fb_axi_slave;
  localparam int EW = 37;  // {rid[3:0], rlast, rdata[31:0]}
`ifdef DISPLAY_FB_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0]  S_AXI_AWID = '0, S_AXI_ARID = '0, S_AXI_BID, S_AXI_RID;
  logic [31:0] S_AXI_AWADDR = '0, S_AXI_ARADDR = '0, S_AXI_WDATA = '0, S_AXI_RDATA;
  logic [7:0]  S_AXI_AWLEN = '0, S_AXI_ARLEN = '0;
  logic [1:0]  S_AXI_AWBURST = '0, S_AXI_ARBURST = '0, S_AXI_BRESP, S_AXI_RRESP;
  logic [2:0]  S_AXI_AWSIZE = 3'd2, S_AXI_ARSIZE = 3'd2;
  logic [3:0]  S_AXI_WSTRB = '0;
  logic S_AXI_AWVALID = 0, S_AXI_ARVALID = 0, S_AXI_WVALID = 0, S_AXI_WLAST = 0;
  logic S_AXI_BREADY = 0, S_AXI_RREADY = 0;
  logic S_AXI_AWREADY, S_AXI_ARREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_RVALID, S_AXI_RLAST;
  logic [11:0] pix_addr = '0;
  logic [31:0] pix_data;
  logic [1:0]  fsm_state;

  display_fb_axi_slave dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWID(S_AXI_AWID), .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWLEN(S_AXI_AWLEN),
    .S_AXI_AWSIZE(S_AXI_AWSIZE), .S_AXI_AWBURST(S_AXI_AWBURST), .S_AXI_AWLOCK(1'b0),
    .S_AXI_AWCACHE(4'd0), .S_AXI_AWPROT(3'd0), .S_AXI_AWQOS(4'd0), .S_AXI_AWREGION(4'd0),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WLAST(S_AXI_WLAST),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BID(S_AXI_BID), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
    .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARID(S_AXI_ARID), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARLEN(S_AXI_ARLEN),
    .S_AXI_ARSIZE(S_AXI_ARSIZE), .S_AXI_ARBURST(S_AXI_ARBURST), .S_AXI_ARLOCK(1'b0),
    .S_AXI_ARCACHE(4'd0), .S_AXI_ARPROT(3'd0), .S_AXI_ARQOS(4'd0), .S_AXI_ARREGION(4'd0),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RID(S_AXI_RID), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RLAST(S_AXI_RLAST), .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .pix_addr(pix_addr), .pix_data(pix_data), .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: run still active at %0t, required completion earlier", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- model and scoreboard ----------------
  logic [31:0]   fb [4096];
  logic [EW-1:0] exp_q[$];
  logic [31:0]   wd_q[$];
  logic [3:0]    ws_q[$];
  int  n_vec = 0, n_err = 0;
  bit  stall_prev = 0, wr_done = 0, check_order = 0;
  logic [31:0] stall_data = '0;

  task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'((a / 4) % 4096);
  endfunction

  function automatic logic [31:0] model_next(input logic [31:0] a, input int len, input logic [1:0] burst);
    logic [31:0] bytes;
    if (burst == 2'b00) return a;
    if (burst == 2'b10 && WRAP_EN && (len == 1 || len == 3 || len == 7 || len == 15)) begin
      bytes = 32'((len + 1) * 4);
      return (a - a % bytes) + ((a % bytes) + 32'd4) % bytes;
    end
    return a + 32'd4;
  endfunction

  // Compare process: read beats, stall stability and the one-transaction-at-a-time rule.
  always @(negedge clk) begin
    if (rst_n) begin
      if (stall_prev) begin
        chk("r_stall_valid", EW'(S_AXI_RVALID), EW'(1));
        chk("r_stall_data", EW'(S_AXI_RDATA), EW'(stall_data));
      end
      if (S_AXI_RVALID && S_AXI_RREADY) begin
        if (exp_q.size() == 0) chk("r_extra_beat", EW'(1), EW'(0));
        else chk("r_beat", {S_AXI_RID, S_AXI_RLAST, S_AXI_RDATA}, exp_q.pop_front());
        chk("rresp", EW'(S_AXI_RRESP), EW'(0));
      end
      if (S_AXI_WREADY || S_AXI_BVALID || S_AXI_RVALID)
        chk("one_outstanding", EW'({S_AXI_AWREADY, S_AXI_ARREADY}), EW'(0));
      stall_prev = S_AXI_RVALID && !S_AXI_RREADY;
      stall_data = S_AXI_RDATA;
    end else begin
      stall_prev = 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_reset_outputs();
    chk("rst_ready_valid", EW'({S_AXI_AWREADY, S_AXI_ARREADY, S_AXI_WREADY,
                                S_AXI_BVALID, S_AXI_RVALID, S_AXI_RLAST}), EW'(0));
    chk("rst_ids", EW'({S_AXI_BID, S_AXI_RID}), EW'(0));
    chk("rst_resp", EW'({S_AXI_BRESP, S_AXI_RRESP}), EW'(0));
    chk("rst_rdata", EW'(S_AXI_RDATA), EW'(0));
  endtask

  task automatic write_burst(input logic [3:0] id, input logic [31:0] addr, input int len,
                             input logic [1:0] burst, input int abort_after);
    int n, i;
    bit first;
    logic [31:0] a;
    S_AXI_AWID = id; S_AXI_AWADDR = addr; S_AXI_AWLEN = 8'(len); S_AXI_AWBURST = burst;
    S_AXI_AWVALID = 1;
    n = 0;
    @(negedge clk);
    while (!S_AXI_AWREADY && n < 300) begin @(negedge clk); n++; end
    chk("aw_accept", EW'(S_AXI_AWREADY), EW'(1));
    @(posedge clk); #1;
    S_AXI_AWVALID = 0;
    a = addr; i = 0; n = 0; first = 1;
    while (i <= len && n < 3000) begin
      S_AXI_WVALID = ($urandom_range(0, 3) != 0);
      S_AXI_WDATA = wd_q[i]; S_AXI_WSTRB = ws_q[i]; S_AXI_WLAST = (i == len);
      @(negedge clk);
      if (first) begin chk("wready_latency", EW'(S_AXI_WREADY), EW'(1)); first = 0; end
      if (S_AXI_WVALID && S_AXI_WREADY) begin
        for (int b = 0; b < 4; b++)
          if (ws_q[i][b]) fb[widx(a)][8*b +: 8] = wd_q[i][8*b +: 8];
        a = model_next(a, len, burst);
        i++;
      end
      n++;
      @(posedge clk); #1;
      if (abort_after >= 0 && i == abort_after + 1) begin
        S_AXI_WVALID = 0; S_AXI_WLAST = 0;
        rst_n = 0;
        @(negedge clk);
        check_reset_outputs();
        @(posedge clk); #1;
        rst_n = 1;
        wd_q.delete(); ws_q.delete();
        return;
      end
    end
    chk("w_beats", EW'(i), EW'(len + 1));
    S_AXI_WVALID = 0; S_AXI_WLAST = 0;
    @(negedge clk);
    chk("bvalid_latency", EW'(S_AXI_BVALID), EW'(1));
    repeat ($urandom_range(0, 3)) begin
      @(negedge clk);
      chk("bvalid_hold", EW'(S_AXI_BVALID), EW'(1));
    end
    @(posedge clk); #1;
    S_AXI_BREADY = 1;
    @(negedge clk);
    chk("b_response", EW'({S_AXI_BVALID, S_AXI_BID, S_AXI_BRESP}), EW'({1'b1, id, 2'b00}));
    @(posedge clk); #1;
    S_AXI_BREADY = 0;
    wr_done = 1;
    wd_q.delete(); ws_q.delete();
  endtask

  // rmode 0: RREADY always high, 1: pattern 1,0,0 from the first valid beat, 2: random.
  task automatic read_burst(input logic [3:0] id, input logic [31:0] addr, input int len,
                            input logic [1:0] burst, input int rmode);
    int n, k;
    logic [31:0] a;
    S_AXI_ARID = id; S_AXI_ARADDR = addr; S_AXI_ARLEN = 8'(len); S_AXI_ARBURST = burst;
    S_AXI_ARVALID = 1;
    n = 0;
    @(negedge clk);
    while (!S_AXI_ARREADY && n < 300) begin @(negedge clk); n++; end
    chk("ar_accept", EW'(S_AXI_ARREADY), EW'(1));
    if (check_order) chk("write_first", EW'(wr_done), EW'(1));
    @(posedge clk); #1;
    S_AXI_ARVALID = 0;
    a = addr;
    for (int i = 0; i <= len; i++) begin
      exp_q.push_back({id, (i == len), fb[widx(a)]});
      a = model_next(a, len, burst);
    end
    k = 0;
    while (exp_q.size() != 0 && k < 3000) begin
      case (rmode)
        0:       S_AXI_RREADY = 1;
        1:       S_AXI_RREADY = (k % 3 == 1);
        default: S_AXI_RREADY = ($urandom_range(0, 2) != 0);
      endcase
      @(negedge clk);
      if (k == 0) chk("rvalid_latency_1", EW'(S_AXI_RVALID), EW'(0));
      if (k == 1) chk("rvalid_latency_2", EW'(S_AXI_RVALID), EW'(1));
      k++;
      @(posedge clk); #1;
    end
    chk("r_drained", EW'(exp_q.size()), EW'(0));
    S_AXI_RREADY = 0;
  endtask

  task automatic pix_check(input int w);
    pix_addr = 12'(w);
    @(posedge clk);
    @(negedge clk);
    chk("pix_data", EW'(pix_data), EW'(fb[w]));
    @(posedge clk); #1;
  endtask

  // ---------------- main sequence ----------------
  logic [31:0] lit [4];
  logic [31:0] old_d [16], new_d [16];
  logic [31:0] a;
  int len;
  logic [1:0] burst;

  initial begin
    repeat (2) @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1;
    rst_n = 1;

    chk("model_incr", EW'(model_next(32'h10, 3, 2'b01)), EW'(32'h14));
    chk("model_fixed", EW'(model_next(32'h10, 3, 2'b00)), EW'(32'h10));
    chk("model_wrap", EW'(model_next(32'hC, 3, 2'b10)), EW'(WRAP_EN ? 32'h0 : 32'h10));
    chk("model_wrap_badlen", EW'(model_next(32'hC, 2, 2'b10)), EW'(32'h10));
    chk("model_alias", EW'(widx(32'h0000_4008)), EW'(2));

    // Fill the whole RAM with maximum-length bursts so every read has a known model value.
    for (int blk = 0; blk < 16; blk++) begin
      for (int i = 0; i < 256; i++) begin wd_q.push_back($urandom); ws_q.push_back(4'hF); end
      write_burst(4'(blk), 32'(blk * 1024), 255, 2'b01, -1);
    end

    // 16-beat INCR write then read at 0.
    for (int i = 0; i < 16; i++) begin
      wd_q.push_back(i == 0 ? 32'hFFFF_FFFF : (i == 15 ? 32'h00AB_CDEF : $urandom));
      ws_q.push_back(4'hF);
    end
    write_burst(4'h1, 32'h0, 15, 2'b01, -1);
    chk("incr_model_first", EW'(fb[0]), EW'(32'hFFFF_FFFF));
    chk("incr_model_last", EW'(fb[15]), EW'(32'h00AB_CDEF));
    read_burst(4'h2, 32'h0, 15, 2'b01, 0);

    // WRAP read at 0x8 over words A0..A5.
    for (int i = 0; i < 6; i++) begin wd_q.push_back(32'hA0 + 32'(i)); ws_q.push_back(4'hF); end
    write_burst(4'h3, 32'h0, 5, 2'b01, -1);
`ifdef DISPLAY_FB_WRAP_EN
    lit = '{32'hA2, 32'hA3, 32'hA0, 32'hA1};
`else
    lit = '{32'hA2, 32'hA3, 32'hA4, 32'hA5};
`endif
    a = 32'h8;
    for (int i = 0; i < 4; i++) begin
      chk("wrap_model_seq", EW'(fb[widx(a)]), EW'(lit[i]));
      a = model_next(a, 3, 2'b10);
    end
    read_burst(4'h4, 32'h8, 3, 2'b10, 0);

    // Partial strobe write, readback and pixel port.
    wd_q.push_back(32'hFFFF_FFFF); ws_q.push_back(4'hF);
    write_burst(4'h5, 32'h40, 0, 2'b01, -1);
    wd_q.push_back(32'h1234_5678); ws_q.push_back(4'b0011);
    write_burst(4'h6, 32'h40, 0, 2'b01, -1);
    chk("strb_model", EW'(fb[16]), EW'(32'hFFFF_5678));
    read_burst(4'h7, 32'h40, 0, 2'b01, 0);
    pix_check(16);
    chk("pix_strb_literal", EW'(pix_data), EW'(32'hFFFF_5678));

    // Simultaneous AW and AR on the same address.
    wd_q.push_back(32'hCAFE_F00D); ws_q.push_back(4'hF);
    wr_done = 0; check_order = 1;
    fork
      write_burst(4'h8, 32'h80, 0, 2'b01, -1);
      read_burst(4'h9, 32'h80, 0, 2'b01, 0);
    join
    check_order = 0;
    chk("collide_model", EW'(fb[32]), EW'(32'hCAFE_F00D));

    // 8-beat read under RREADY backpressure.
    read_burst(4'hA, 32'h0, 7, 2'b01, 1);

    // Reset in the middle of a 16-beat write.
    for (int i = 0; i < 16; i++) begin
      old_d[i] = $urandom; new_d[i] = $urandom;
      wd_q.push_back(old_d[i]); ws_q.push_back(4'hF);
    end
    write_burst(4'hB, 32'h100, 15, 2'b01, -1);
    for (int i = 0; i < 16; i++) begin wd_q.push_back(new_d[i]); ws_q.push_back(4'hF); end
    write_burst(4'hC, 32'h100, 15, 2'b01, 5);
    chk("abort_model_new", EW'(fb[69]), EW'(new_d[5]));
    chk("abort_model_old", EW'(fb[70]), EW'(old_d[6]));
    read_burst(4'hD, 32'h100, 15, 2'b01, 2);
    for (int i = 0; i < 16; i++) begin wd_q.push_back($urandom); ws_q.push_back(4'hF); end
    write_burst(4'hE, 32'h100, 15, 2'b01, -1);
    read_burst(4'hF, 32'h100, 15, 2'b01, 2);

    // Random traffic over all burst types, lengths, strobes and aliased addresses.
    for (int t = 0; t < 40; t++) begin
      burst = 2'($urandom_range(0, 3));
      if (burst == 2'b10 && $urandom_range(0, 3) != 0) len = (2 << $urandom_range(0, 3)) - 1;
      else len = $urandom_range(0, 15);
      a = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i <= len; i++) begin
          wd_q.push_back($urandom); ws_q.push_back(4'($urandom_range(0, 15)));
        end
        write_burst(4'($urandom_range(0, 15)), a, len, burst, -1);
      end else begin
        read_burst(4'($urandom_range(0, 15)), a, len, burst, 2);
      end
      pix_check($urandom_range(0, 4095));
    end

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
